// File: rtl/uart_rx_oversampler_if.sv
// Receive holding-register interface: byte, status flags and consumer pop strobe.
interface uart_rx_oversampler_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;
    logic       read_rx_byte;

    // Receiver side: presents the byte and flags, accepts the pop strobe.
    modport master (
        output rx_byte,
        output rx_valid,
        output parity_err,
        output framing_err,
        output overflow,
        input  read_rx_byte
    );

    // Consumer side: reads the byte and flags, drives the pop strobe.
    modport slave (
        input  rx_byte,
        input  rx_valid,
        input  parity_err,
        input  framing_err,
        input  overflow,
        output read_rx_byte
    );
endinterface

// File: rtl/uart_rx_oversampler.sv
// UART receive front end: 16x oversampling, deframing, one-entry holding register.
module uart_rx_oversampler #(
    parameter int unsigned SAMPLE_MAJORITY = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          baud_clock,
    input  logic                          rx,
    input  logic                          bit8,
    input  logic                          parity_en,
    input  logic                          odd_n_even,
    output logic                          rx_busy,
    uart_rx_oversampler_if.master         rxif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [2:0]  samp_q, samp_d;
    logic [3:0]  samp_cnt_q, samp_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        par_q, par_d;
    logic        bit8_q, bit8_d;
    logic        pen_q, pen_d;
    logic        odd_q, odd_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        ovf_q, ovf_d;

    logic [3:0]  cnt_inc;
    logic        decide;
    logic        maj;
    logic        bit_val;
    logic        load_evt;
    logic [2:0]  last_bit;

    // Decision value and decision-point strobe derived from the registered samples.
    always_comb begin
        maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
        bit_val  = (SAMPLE_MAJORITY != 0) ? maj : samp_q[0];
        cnt_inc  = samp_cnt_q + 4'd1;
        decide   = baud_clock && (cnt_inc == 4'd8);
        last_bit = bit8_q ? 3'd7 : 3'd6;
        samp_d   = baud_clock ? {samp_q[1:0], rx_s_q} : samp_q;
    end

    // Frame state machine: next state, counters, shift register, parity accumulation.
    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        bit8_d     = bit8_q;
        pen_d      = pen_q;
        odd_d      = odd_q;
        load_evt   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (baud_clock && !rx_s_q) begin
                    samp_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_clock) samp_cnt_d = cnt_inc;
                if (decide) begin
                    if (bit_val) begin
                        state_d = S_IDLE;
                    end else begin
                        bit_cnt_d = '0;
                        par_d     = 1'b0;
                        bit8_d    = bit8;
                        pen_d     = parity_en;
                        odd_d     = odd_n_even;
                        state_d   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (baud_clock) samp_cnt_d = cnt_inc;
                if (decide) begin
                    shreg_d   = {bit_val, shreg_q[7:1]};
                    par_d     = par_q ^ bit_val;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == last_bit) state_d = pen_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (baud_clock) samp_cnt_d = cnt_inc;
                if (decide) begin
                    // par_q becomes the mismatch flag: the total ones-count parity must equal odd_n_even.
                    par_d   = par_q ^ bit_val ^ odd_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_clock) samp_cnt_d = cnt_inc;
                if (decide) begin
                    load_evt = 1'b1;
                    state_d  = bit_val ? S_IDLE : S_BREAK_WAIT;
                end
            end
            S_BREAK_WAIT: begin
                if (baud_clock && rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Holding register: load at the stop decision, drop on overflow, clear on pop.
    always_comb begin
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovf_d      = ovf_q;
        if (load_evt) begin
            if (!rx_valid_q || rxif.read_rx_byte) begin
                rx_byte_d  = bit8_q ? shreg_q : {1'b0, shreg_q[7:1]};
                perr_d     = pen_q & par_q;
                ferr_d     = ~bit_val;
                rx_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (rxif.read_rx_byte && rx_valid_q) begin
            rx_valid_d = 1'b0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            ovf_d      = 1'b0;
        end
    end

    // All registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            samp_q     <= 3'b111;
            state_q    <= S_IDLE;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            bit8_q     <= 1'b0;
            pen_q      <= 1'b0;
            odd_q      <= 1'b0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            samp_q     <= samp_d;
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            bit8_q     <= bit8_d;
            pen_q      <= pen_d;
            odd_q      <= odd_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
        end
    end

    assign rx_busy          = (state_q != S_IDLE);
    assign rxif.rx_byte     = rx_byte_q;
    assign rxif.rx_valid    = rx_valid_q;
    assign rxif.parity_err  = perr_q;
    assign rxif.framing_err = ferr_q;
    assign rxif.overflow    = ovf_q;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Scoreboard bench for uart_rx_oversampler: serial frames in, expected bytes queued, monitor compares.
module tb_uart_rx_oversampler;

    typedef struct packed {
        logic [7:0] b;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n, baud_clock, rx, bit8, parity_en, odd_n_even, rx_busy;
    logic mon_pop, stim_pop;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          div = 1;
    bit          auto_pop = 1'b1;
    int unsigned start_cycle = 0;
    int unsigned lat_expect = 0;
    exp_t        expq[$];

    uart_rx_oversampler_if ifc();
    assign ifc.read_rx_byte = mon_pop | stim_pop;

    uart_rx_oversampler #(.SAMPLE_MAJORITY(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .baud_clock (baud_clock),
        .rx         (rx),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .rx_busy    (rx_busy),
        .rxif       (ifc.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // 16x tick generator: one tick every div clocks.
    initial begin
        int k = 0;
        baud_clock = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            k++;
            if (k >= div) k = 0;
            baud_clock = (k == 0);
        end
    end

    // Monitor: compares each newly presented byte against the scoreboard, optionally pops it.
    initial begin
        bit   seen = 1'b0;
        bit   pop_done = 1'b0;
        exp_t e;
        mon_pop = 1'b0;
        forever begin
            @(negedge clk);
            mon_pop = 1'b0;
            if (pop_done || !ifc.rx_valid) seen = 1'b0;
            if (ifc.rx_valid && !seen && reset_n) begin
                seen = 1'b1;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", ifc.rx_byte);
                end else begin
                    e = expq.pop_front();
                    chk("rx_byte", {24'd0, ifc.rx_byte}, {24'd0, e.b});
                    chk("parity_err", {31'd0, ifc.parity_err}, {31'd0, e.pe});
                    chk("framing_err", {31'd0, ifc.framing_err}, {31'd0, e.fe});
                    chk("overflow", {31'd0, ifc.overflow}, {31'd0, e.ov});
                    if (lat_expect != 0) chk("latency", cyc - start_cycle, lat_expect);
                end
                if (auto_pop) mon_pop = 1'b1;
            end
            pop_done = (mon_pop || stim_pop) && ifc.rx_valid;
        end
    end

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (16 * div) @(posedge clk);
        #1;
    endtask

    // Reference: expected byte is the data masked to the word length, parity error iff the
    // transmitted parity bit differs from the correct one, framing error iff the stop bit is low.
    task automatic send_frame(input logic [7:0] d, input bit b8, input bit pen, input bit odd,
                              input bit flip_par, input bit stop_v, input bit push, input bit ovf_exp);
        int         n;
        logic [7:0] dm;
        logic       par;
        exp_t       e;
        n   = b8 ? 8 : 7;
        dm  = b8 ? d : {1'b0, d[6:0]};
        par = (^dm) ^ odd;
        if (push) begin
            e.b  = dm;
            e.pe = pen & flip_par;
            e.fe = !stop_v;
            e.ov = ovf_exp;
            expq.push_back(e);
        end
        bit8       = b8;
        parity_en  = pen;
        odd_n_even = odd;
        @(posedge clk);
        #1;
        start_cycle = cyc;
        hold_bit(1'b0);
        for (int i = 0; i < n; i++) hold_bit(dm[i]);
        if (pen) hold_bit(par ^ flip_par);
        hold_bit(stop_v);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((expq.size() != 0 || ifc.rx_valid) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_timeout", {31'd0, (t >= 3000)}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_byte"}, {24'd0, ifc.rx_byte}, 32'd0);
        chk({tag, "_rx_valid"}, {31'd0, ifc.rx_valid}, 32'd0);
        chk({tag, "_parity_err"}, {31'd0, ifc.parity_err}, 32'd0);
        chk({tag, "_framing_err"}, {31'd0, ifc.framing_err}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, ifc.overflow}, 32'd0);
        chk({tag, "_rx_busy"}, {31'd0, rx_busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        bit b8, pen, odd, flip, stopv;
        rx = 1'b1; reset_n = 1'b0; stim_pop = 1'b0;
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Latency in clocks from driving the start bit: 2 synchroniser + 1 edge-detect tick + frame ticks.
        lat_expect = 3 + 152;
        send_frame(8'hA5, 1, 0, 0, 0, 1, 1, 0);
        wait_drain();
        lat_expect = 3 + 152;
        send_frame(8'h41, 0, 1, 0, 0, 1, 1, 0);
        wait_drain();
        lat_expect = 0;
        send_frame(8'h41, 0, 1, 0, 1, 1, 1, 0);
        wait_drain();
        lat_expect = 3 + 168;
        send_frame(8'h96, 1, 1, 1, 0, 1, 1, 0);
        wait_drain();
        lat_expect = 0;

        // Framing error followed by a held-low line.
        send_frame(8'h3C, 1, 0, 0, 0, 0, 1, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("break_busy", {31'd0, rx_busy}, 32'd1);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("break_release_busy", {31'd0, rx_busy}, 32'd0);
        wait_drain();

        // Short low glitch: false start.
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("glitch_busy", {31'd0, rx_busy}, 32'd0);
        chk("glitch_valid", {31'd0, ifc.rx_valid}, 32'd0);

        // Overflow: second byte dropped while the first is still held.
        auto_pop = 1'b0;
        send_frame(8'h11, 1, 0, 0, 0, 1, 1, 0);
        send_frame(8'h22, 1, 0, 0, 0, 1, 0, 0);
        chk("ovf_byte", {24'd0, ifc.rx_byte}, 32'h11);
        chk("ovf_flag", {31'd0, ifc.overflow}, 32'd1);
        chk("ovf_valid", {31'd0, ifc.rx_valid}, 32'd1);
        stim_pop = 1'b1;
        @(posedge clk);
        #1;
        stim_pop = 1'b0;
        chk("pop_valid", {31'd0, ifc.rx_valid}, 32'd0);
        chk("pop_ovf", {31'd0, ifc.overflow}, 32'd0);
        chk("pop_byte_kept", {24'd0, ifc.rx_byte}, 32'h11);

        // Pop coinciding with the second byte's stop decision.
        send_frame(8'h11, 1, 0, 0, 0, 1, 1, 0);
        fork
            send_frame(8'h22, 1, 0, 0, 0, 1, 1, 0);
            begin
                @(posedge clk);
                #1;
                repeat (154) @(posedge clk);
                #1;
                stim_pop = 1'b1;
                @(posedge clk);
                #1;
                stim_pop = 1'b0;
            end
        join
        chk("popload_valid", {31'd0, ifc.rx_valid}, 32'd1);
        chk("popload_byte", {24'd0, ifc.rx_byte}, 32'h22);
        chk("popload_ovf", {31'd0, ifc.overflow}, 32'd0);
        stim_pop = 1'b1;
        @(posedge clk);
        #1;
        stim_pop = 1'b0;

        // Reset in the middle of a data bit, with a byte held.
        send_frame(8'h5A, 1, 0, 0, 0, 1, 1, 0);
        @(posedge clk);
        #1;
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b0);
        rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("pre_reset_busy", {31'd0, rx_busy}, 32'd1);
        chk("pre_reset_valid", {31'd0, ifc.rx_valid}, 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("midreset");
        reset_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("post_reset_busy", {31'd0, rx_busy}, 32'd0);
        chk("post_reset_valid", {31'd0, ifc.rx_valid}, 32'd0);
        auto_pop = 1'b1;

        // Randomised frames across word lengths, parity modes, tick rates and line faults.
        for (int f = 0; f < 40; f++) begin
            if (f % 10 == 0) begin
                wait_drain();
                div = $urandom_range(1, 3);
                repeat (8) @(posedge clk);
                #1;
            end
            d     = 8'($urandom);
            b8    = 1'($urandom);
            pen   = 1'($urandom);
            odd   = 1'($urandom);
            flip  = ($urandom_range(0, 3) == 0);
            stopv = ($urandom_range(0, 4) != 0);
            send_frame(d, b8, pen, odd, flip, stopv, 1, 0);
            if (!stopv) begin
                repeat ($urandom_range(0, 30) * div) @(posedge clk);
                #1;
                rx = 1'b1;
                repeat (4 * div) @(posedge clk);
                #1;
            end
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
        end
        wait_drain();
        chk("queue_empty", expq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
